// File: rtl/kof_anim_pkg.sv
// Shared definitions for the KOF character animation sequencers and sprite renderers.
// Holds the state encoding and the default frame counts.
package kof_anim_pkg;

    localparam int unsigned CNT_W = 8;

    localparam int unsigned FRAME_DIV_DEF      = 4;
    localparam int unsigned STAND_FRAMES_DEF   = 8;
    localparam int unsigned ATTACK_FRAMES_DEF  = 6;
    localparam int unsigned MOVEL_FRAMES_DEF   = 10;
    localparam int unsigned MOVER_FRAMES_DEF   = 9;
    localparam int unsigned DEFENSE_FRAMES_DEF = 1;
    localparam int unsigned HURT_FRAMES_DEF    = 5;

    typedef enum logic [CNT_W-1:0] {
        ST_STAND   = 8'd0,
        ST_ATTACK  = 8'd1,
        ST_MOVEL   = 8'd2,
        ST_MOVER   = 8'd3,
        ST_DEFENSE = 8'd4,
        ST_HURT    = 8'd5
    } anim_state_t;

endpackage

// File: rtl/anim_tick_gen.sv
// Turns the asynchronous frame strobe into a one-Clk animation tick,
// emitted once every FRAME_DIV rising edges of frame_clk.
module anim_tick_gen
    import kof_anim_pkg::*;
#(
    parameter int unsigned FRAME_DIV = FRAME_DIV_DEF
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic anim_tick
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(FRAME_DIV - 1);

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic [CNT_W-1:0] div_cnt;
    logic             rise;

    assign rise = sync2 & ~sync3;

    // sync1/sync2 resolve metastability; sync3 is the edge-detect history
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            div_cnt   <= '0;
            anim_tick <= 1'b0;
        end else begin
            sync1     <= frame_clk;
            sync2     <= sync1;
            sync3     <= sync2;
            anim_tick <= 1'b0;
            if (rise) begin
                if (div_cnt >= DIV_LAST) begin
                    div_cnt   <= '0;
                    anim_tick <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/character2_anim_ctrl.sv
// Animation sequencer for character 2: selects the sprite state and the frame
// index within it, advancing once per animation tick.
module character2_anim_ctrl
    import kof_anim_pkg::*;
#(
    parameter int unsigned FRAME_DIV      = FRAME_DIV_DEF,
    parameter int unsigned STAND_FRAMES   = STAND_FRAMES_DEF,
    parameter int unsigned ATTACK_FRAMES  = ATTACK_FRAMES_DEF,
    parameter int unsigned MOVEL_FRAMES   = MOVEL_FRAMES_DEF,
    parameter int unsigned MOVER_FRAMES   = MOVER_FRAMES_DEF,
    parameter int unsigned DEFENSE_FRAMES = DEFENSE_FRAMES_DEF,
    parameter int unsigned HURT_FRAMES    = HURT_FRAMES_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic             move_l2,
    input  logic             move_r2,
    input  logic             defend2,
    input  logic             attack_req2,
    input  logic             character2_hurt,
    output logic [CNT_W-1:0] character2_state,
    output logic [CNT_W-1:0] frame_num,
    output logic             attack,
    output logic             busy
);

    logic             anim_tick;
    anim_state_t      state_q;
    anim_state_t      state_d;
    logic [CNT_W-1:0] frame_d;
    logic [CNT_W-1:0] last_frame;
    logic             hit_pend_q;
    logic             hit_pend_d;
    logic             atk_pend_q;
    logic             atk_pend_d;
    logic             hit_in;
    logic             atk_in;
    logic             one_shot;
    logic             attack_d;
    logic             busy_d;

    anim_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .anim_tick (anim_tick)
    );

    function automatic logic [CNT_W-1:0] frames_last(input anim_state_t s);
        case (s)
            ST_ATTACK:  return CNT_W'(ATTACK_FRAMES - 1);
            ST_MOVEL:   return CNT_W'(MOVEL_FRAMES - 1);
            ST_MOVER:   return CNT_W'(MOVER_FRAMES - 1);
            ST_DEFENSE: return CNT_W'(DEFENSE_FRAMES - 1);
            ST_HURT:    return CNT_W'(HURT_FRAMES - 1);
            default:    return CNT_W'(STAND_FRAMES - 1);
        endcase
    endfunction

    assign character2_state = CNT_W'(state_q);

    // Next state, frame index and request latches; a live pulse counts as pending
    always_comb begin
        hit_in     = hit_pend_q | character2_hurt;
        atk_in     = atk_pend_q | attack_req2;
        last_frame = frames_last(state_q);
        one_shot   = (state_q == ST_ATTACK) || (state_q == ST_HURT);
        state_d    = state_q;
        frame_d    = frame_num;
        hit_pend_d = hit_in;
        atk_pend_d = atk_in;

        if (anim_tick) begin
            if (hit_in) begin
                state_d    = ST_HURT;
                frame_d    = '0;
                hit_pend_d = hit_pend_q & character2_hurt;
            end else if (one_shot && (frame_num < last_frame)) begin
                frame_d = frame_num + CNT_W'(1);
            end else begin
                if (atk_in) begin
                    state_d    = ST_ATTACK;
                    atk_pend_d = atk_pend_q & attack_req2;
                end else if (defend2) begin
                    state_d = ST_DEFENSE;
                end else if (move_l2 && move_r2) begin
                    state_d = ST_STAND;
                end else if (move_l2) begin
                    state_d = ST_MOVEL;
                end else if (move_r2) begin
                    state_d = ST_MOVER;
                end else begin
                    state_d = ST_STAND;
                end

                if ((state_d != state_q) || (frame_num >= last_frame)) begin
                    frame_d = '0;
                end else begin
                    frame_d = frame_num + CNT_W'(1);
                end
            end
        end

        attack_d = (state_d == ST_ATTACK);
        busy_d   = (state_d == ST_ATTACK) || (state_d == ST_HURT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_STAND;
            frame_num  <= '0;
            attack     <= 1'b0;
            busy       <= 1'b0;
            hit_pend_q <= 1'b0;
            atk_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_num  <= frame_d;
            attack     <= attack_d;
            busy       <= busy_d;
            hit_pend_q <= hit_pend_d;
            atk_pend_q <= atk_pend_d;
        end
    end

endmodule
